cic_d_mc: RTL and testbench

CIC_D_MC -- requirements
Module: cic_d_mc

---
 rtl/cic_d_mc_pkg.sv | 43 ++++
 rtl/cic_d_mc_if.sv | 12 +
 rtl/cic_d_mc_comb_stage.sv | 50 +++++
 rtl/cic_d_mc.sv | 156 +++++++++++++++
 tb/tb_cic_d_mc.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cic_d_mc_pkg.sv
// rtl/cic_d_mc_pkg.sv - shared width helpers and saturation limits for the CIC decimators
package cic_pkg;

    localparam int WIDE_W = 128;
    typedef logic signed [WIDE_W-1:0] wide_t;

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

    function automatic int acc_w(input int inp_dw, input int n, input int r_max, input int m);
        return inp_dw + n * clog2(r_max * m);
    endfunction

    function automatic int ch_w(input int ch_num);
        return (clog2(ch_num) < 1) ? 1 : clog2(ch_num);
    endfunction

    function automatic int r_w(input int r_max);
        return clog2(r_max + 1);
    endfunction

    function automatic int sh_w(input int acc);
        return clog2(acc);
    endfunction

    function automatic wide_t sat_hi(input int out_dw);
        return (wide_t'(1) << (out_dw - 1)) - wide_t'(1);
    endfunction

    function automatic wide_t sat_lo(input int out_dw);
        return -(wide_t'(1) << (out_dw - 1));
    endfunction

endpackage

// File: rtl/cic_d_mc_if.sv
// rtl/cic_d_mc_if.sv - sample stream link: data, channel tag and valid qualifier
interface cic_d_mc_if #(
    parameter int DW = 8,
    parameter int CW = 1
);
    logic signed [DW-1:0] tdata;
    logic [CW-1:0]        tch;
    logic                 tvalid;

    modport master (output tdata, tch, tvalid);
    modport slave  (input  tdata, tch, tvalid);
endinterface

// File: rtl/cic_d_mc_comb_stage.sv
// rtl/cic_d_mc_comb_stage.sv - one comb stage: per-channel M-deep delay, subtract, one-cycle pipe
module cic_comb_stage #(
    parameter int ACC_W  = 66,
    parameter int CH_W   = 2,
    parameter int CH_NUM = 4,
    parameter int CIC_M  = 1
) (
    input logic          clk,
    input logic          reset_n,
    input logic          clear,
    cic_d_mc_if.slave    up,
    cic_d_mc_if.master   dn
);
    typedef logic signed [ACC_W-1:0] acc_t;

    acc_t            dly [CH_NUM][CIC_M];
    acc_t            data_q;
    logic [CH_W-1:0] ch_q;
    logic            vld_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < CH_NUM; c++)
                for (int j = 0; j < CIC_M; j++)
                    dly[c][j] <= '0;
            data_q <= '0;
            ch_q   <= '0;
            vld_q  <= 1'b0;
        end else if (clear) begin
            for (int c = 0; c < CH_NUM; c++)
                for (int j = 0; j < CIC_M; j++)
                    dly[c][j] <= '0;
            vld_q <= 1'b0;
        end else begin
            vld_q <= up.tvalid;
            if (up.tvalid) begin
                data_q <= up.tdata - dly[up.tch][CIC_M-1];
                ch_q   <= up.tch;
                dly[up.tch][0] <= up.tdata;
                for (int j = 1; j < CIC_M; j++)
                    dly[up.tch][j] <= dly[up.tch][j-1];
            end
        end
    end

    assign dn.tdata  = data_q;
    assign dn.tch    = ch_q;
    assign dn.tvalid = vld_q;

endmodule

// File: rtl/cic_d_mc.sv
// rtl/cic_d_mc.sv - multichannel CIC decimator with runtime ratio, output shift and saturation
module cic_d_mc
    import cic_pkg::*;
#(
    parameter int INP_DW    = 17,
    parameter int OUT_DW    = 14,
    parameter int CIC_N     = 7,
    parameter int CIC_M     = 1,
    parameter int CIC_R_MAX = 128,
    parameter int CH_NUM    = 4,
    localparam int CH_W     = ch_w(CH_NUM),
    localparam int R_W      = r_w(CIC_R_MAX),
    localparam int ACC_W    = acc_w(INP_DW, CIC_N, CIC_R_MAX, CIC_M),
    localparam int SH_W     = sh_w(ACC_W)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clear,
    input  logic [R_W-1:0]           cfg_r,
    input  logic [SH_W-1:0]          cfg_shift,
    input  logic signed [INP_DW-1:0] inp_samp_data,
    input  logic [CH_W-1:0]          inp_samp_ch,
    input  logic                     inp_samp_str,
    output logic signed [OUT_DW-1:0] out_samp_data,
    output logic [CH_W-1:0]          out_samp_ch,
    output logic                     out_samp_str,
    output logic                     out_sat
);
    typedef logic signed [ACC_W-1:0] acc_t;

    localparam wide_t          HI_WIDE  = sat_hi(OUT_DW);
    localparam wide_t          LO_WIDE  = sat_lo(OUT_DW);
    localparam acc_t           SAT_HI   = HI_WIDE[ACC_W-1:0];
    localparam acc_t           SAT_LO   = LO_WIDE[ACC_W-1:0];
    localparam logic [R_W-1:0] R_MAX_V  = R_W'(CIC_R_MAX);
    localparam logic [SH_W-1:0] SH_MAX_V = SH_W'(ACC_W - OUT_DW);

    logic [R_W-1:0]  r_q;
    logic [SH_W-1:0] sh_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_q  <= R_MAX_V;
            sh_q <= SH_MAX_V;
        end else if (clear) begin
            r_q  <= (cfg_r < R_W'(2)) ? R_W'(2) : ((cfg_r > R_MAX_V) ? R_MAX_V : cfg_r);
            sh_q <= (cfg_shift > SH_MAX_V) ? SH_MAX_V : cfg_shift;
        end
    end

    acc_t            integ [CH_NUM][CIC_N];
    logic [R_W-1:0]  cnt [CH_NUM];
    acc_t            integ_nxt [CIC_N];
    acc_t            samp_ext;
    logic            samp_ok;
    logic            dec_hit;
    acc_t            ent_data;
    logic [CH_W-1:0] ent_ch;
    logic            ent_vld;

    assign samp_ext = {{(ACC_W-INP_DW){inp_samp_data[INP_DW-1]}}, inp_samp_data};
    assign samp_ok  = inp_samp_str && (32'(inp_samp_ch) < CH_NUM) && !clear;
    assign dec_hit  = (cnt[inp_samp_ch] == r_q - R_W'(1));

    // Whole integrator cascade settles in one cycle, so each stage sees the new value of the one before.
    always_comb begin
        integ_nxt[0] = integ[inp_samp_ch][0] + samp_ext;
        for (int k = 1; k < CIC_N; k++)
            integ_nxt[k] = integ[inp_samp_ch][k] + integ_nxt[k-1];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < CH_NUM; c++) begin
                cnt[c] <= '0;
                for (int k = 0; k < CIC_N; k++)
                    integ[c][k] <= '0;
            end
            ent_data <= '0;
            ent_ch   <= '0;
            ent_vld  <= 1'b0;
        end else if (clear) begin
            for (int c = 0; c < CH_NUM; c++) begin
                cnt[c] <= '0;
                for (int k = 0; k < CIC_N; k++)
                    integ[c][k] <= '0;
            end
            ent_vld <= 1'b0;
        end else begin
            ent_vld <= samp_ok && dec_hit;
            if (samp_ok) begin
                for (int k = 0; k < CIC_N; k++)
                    integ[inp_samp_ch][k] <= integ_nxt[k];
                cnt[inp_samp_ch] <= dec_hit ? '0 : cnt[inp_samp_ch] + R_W'(1);
                if (dec_hit) begin
                    ent_data <= integ_nxt[CIC_N-1];
                    ent_ch   <= inp_samp_ch;
                end
            end
        end
    end

    cic_d_mc_if #(.DW(ACC_W), .CW(CH_W)) link [CIC_N+1] ();

    assign link[0].tdata  = ent_data;
    assign link[0].tch    = ent_ch;
    assign link[0].tvalid = ent_vld;

    for (genvar g = 0; g < CIC_N; g++) begin : g_comb
        cic_comb_stage #(
            .ACC_W  (ACC_W),
            .CH_W   (CH_W),
            .CH_NUM (CH_NUM),
            .CIC_M  (CIC_M)
        ) u_stage (
            .clk     (clk),
            .reset_n (reset_n),
            .clear   (clear),
            .up      (link[g]),
            .dn      (link[g+1])
        );
    end

    acc_t comb_out;
    acc_t shifted;

    assign comb_out = link[CIC_N].tdata;
    assign shifted  = comb_out >>> sh_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_samp_data <= '0;
            out_samp_ch   <= '0;
            out_samp_str  <= 1'b0;
            out_sat       <= 1'b0;
        end else if (clear) begin
            out_samp_str <= 1'b0;
        end else begin
            out_samp_str <= link[CIC_N].tvalid;
            if (link[CIC_N].tvalid) begin
                out_samp_ch <= link[CIC_N].tch;
                if (shifted > SAT_HI) begin
                    out_samp_data <= SAT_HI[OUT_DW-1:0];
                    out_sat       <= 1'b1;
                end else if (shifted < SAT_LO) begin
                    out_samp_data <= SAT_LO[OUT_DW-1:0];
                    out_sat       <= 1'b1;
                end else begin
                    out_samp_data <= shifted[OUT_DW-1:0];
                    out_sat       <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cic_d_mc.sv
// tb/tb_cic_d_mc.sv - bench for cic_d_mc against a convolution model of the CIC response
module tb_cic_d_mc;
    import cic_pkg::*;

    localparam int INP_DW    = 17;
    localparam int OUT_DW    = 14;
    localparam int CIC_N     = 3;
    localparam int CIC_M     = 1;
    localparam int CIC_R_MAX = 16;
    localparam int CH_NUM    = 5;
    localparam int CH_W      = ch_w(CH_NUM);
    localparam int R_W       = r_w(CIC_R_MAX);
    localparam int ACC_W     = acc_w(INP_DW, CIC_N, CIC_R_MAX, CIC_M);
    localparam int SH_W      = sh_w(ACC_W);

    typedef struct {
        longint data;
        int     ch;
        int     sat;
        int     cyc;
    } rec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     reset_n;
    logic                     clear;
    logic [R_W-1:0]           cfg_r;
    logic [SH_W-1:0]          cfg_shift;
    logic signed [OUT_DW-1:0] out_data;
    logic [CH_W-1:0]          out_ch;
    logic                     out_str;
    logic                     out_sat;

    cic_d_mc_if #(.DW(INP_DW), .CW(CH_W)) src ();

    cic_d_mc #(
        .INP_DW(INP_DW), .OUT_DW(OUT_DW), .CIC_N(CIC_N), .CIC_M(CIC_M),
        .CIC_R_MAX(CIC_R_MAX), .CH_NUM(CH_NUM)
    ) dut (
        .clk(clk), .reset_n(reset_n), .clear(clear), .cfg_r(cfg_r), .cfg_shift(cfg_shift),
        .inp_samp_data(src.tdata), .inp_samp_ch(src.tch), .inp_samp_str(src.tvalid),
        .out_samp_data(out_data), .out_samp_ch(out_ch), .out_samp_str(out_str), .out_sat(out_sat)
    );

    int     checks = 0;
    int     failures = 0;
    int     cyc = 0;
    rec_t   exp_q[$];
    rec_t   got_q[$];
    longint hist [CH_NUM][$];
    longint h[$];
    int     m_cnt [CH_NUM];
    int     m_r;
    int     m_sh;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        if (out_str === 1'b1)
            got_q.push_back('{longint'(out_data), int'(out_ch), int'(out_sat), cyc});

    task automatic chk(input string tag, input longint got, input longint want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s got=%0d expected=%0d", tag, got, want);
        end
    endtask

    // Impulse response of N cascaded boxcars of length R*M.
    function automatic void build_h(input int rr);
        longint t[$];
        h.delete();
        h.push_back(1);
        repeat (CIC_N) begin
            t.delete();
            for (int i = 0; i < h.size() + rr * CIC_M - 1; i++) begin
                longint s = 0;
                for (int k = 0; k < rr * CIC_M; k++)
                    if (i - k >= 0 && i - k < h.size()) s += h[i-k];
                t.push_back(s);
            end
            h = t;
        end
    endfunction

    function automatic void model_init(input int r, input int sh);
        m_r  = (r < 2) ? 2 : ((r > CIC_R_MAX) ? CIC_R_MAX : r);
        m_sh = (sh > ACC_W - OUT_DW) ? ACC_W - OUT_DW : sh;
        for (int c = 0; c < CH_NUM; c++) begin
            hist[c].delete();
            m_cnt[c] = 0;
        end
        build_h(m_r);
    endfunction

    function automatic void model_push(input int ch, input longint x, input int due);
        longint y = 0;
        longint q;
        longint hi = (longint'(1) << (OUT_DW - 1)) - 1;
        int     n;
        if (ch >= CH_NUM) return;
        hist[ch].push_back(x);
        if (m_cnt[ch] != m_r - 1) begin
            m_cnt[ch]++;
            return;
        end
        m_cnt[ch] = 0;
        n = hist[ch].size() - 1;
        for (int k = 0; k < h.size() && k <= n; k++) y += h[k] * hist[ch][n-k];
        q = y >>> m_sh;
        if (q > hi)            exp_q.push_back('{hi, ch, 1, due});
        else if (q < -hi - 1)  exp_q.push_back('{-hi - 1, ch, 1, due});
        else                   exp_q.push_back('{q, ch, 0, due});
    endfunction

    task automatic drive(input bit s, input int ch, input longint x);
        @(negedge clk);
        clear      = 1'b0;
        cfg_r      = R_W'($urandom);
        cfg_shift  = SH_W'($urandom);
        src.tvalid = s;
        src.tch    = CH_W'(ch);
        src.tdata  = INP_DW'(x);
        if (s) model_push(ch, x, cyc + CIC_N + 2);
    endtask

    task automatic do_clear(input int r, input int sh, input bit s, input int ch, input longint x);
        @(negedge clk);
        clear      = 1'b1;
        cfg_r      = R_W'(r);
        cfg_shift  = SH_W'(sh);
        src.tvalid = s;
        src.tch    = CH_W'(ch);
        src.tdata  = INP_DW'(x);
        while (exp_q.size() > 0 && exp_q[$].cyc > cyc) void'(exp_q.pop_back());
        model_init(r, sh);
    endtask

    task automatic drain();
        repeat (CIC_N + 4) drive(0, 0, 0);
    endtask

    task automatic check_phase(input string tag, output longint sum);
        drain();
        chk({tag, ".count"}, got_q.size(), exp_q.size());
        sum = 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            chk($sformatf("%s[%0d].data", tag, i), got_q[i].data, exp_q[i].data);
            chk($sformatf("%s[%0d].ch", tag, i), got_q[i].ch, exp_q[i].ch);
            chk($sformatf("%s[%0d].sat", tag, i), got_q[i].sat, exp_q[i].sat);
            chk($sformatf("%s[%0d].cyc", tag, i), got_q[i].cyc, exp_q[i].cyc);
        end
        foreach (got_q[i]) sum += got_q[i].data;
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        longint sum;
        longint total;
        int     dc [4];
        int     x;
        dc[0] = 100; dc[1] = -100; dc[2] = 0; dc[3] = 50;

        reset_n = 1'b0; clear = 1'b0; cfg_r = '0; cfg_shift = '0;
        src.tvalid = 1'b0; src.tch = '0; src.tdata = '0;
        model_init(CIC_R_MAX, ACC_W - OUT_DW);
        #12;
        chk("reset.data", longint'(out_data), 0);
        chk("reset.ch", int'(out_ch), 0);
        chk("reset.str", int'(out_str), 0);
        chk("reset.sat", int'(out_sat), 0);
        @(negedge clk); reset_n = 1'b1;

        // Reset-loaded ratio 16 and shift 15
        for (int i = 0; i < 48; i++) drive(1, 1, 30000);
        check_phase("dflt", sum);

        // Impulse at each polyphase offset; all outputs together cover the whole response
        total = 0;
        for (int p = 0; p < 4; p++) begin
            do_clear(4, 0, 0, 0, 0);
            for (int i = 0; i < 16; i++) drive(1, 0, (i == p) ? 1 : 0);
            check_phase("imp", sum);
            total += sum;
        end
        chk("imp.sum", total, 64);

        do_clear(8, 9, 0, 0, 0);
        for (int i = 0; i < 40; i++) drive(1, 0, 1000);
        drain();
        for (int i = 2; i < got_q.size(); i++) chk($sformatf("dc[%0d]", i), got_q[i].data, 1000);
        check_phase("dc", sum);

        do_clear(4, 6, 0, 0, 0);
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 4; c++) drive(1, c, dc[c]);
        drain();
        for (int i = 0; i < got_q.size(); i++) begin
            chk($sformatf("ilv[%0d].order", i), got_q[i].ch, i % 4);
            if (i >= 8) chk($sformatf("ilv[%0d].dc", i), got_q[i].data, dc[i % 4]);
        end
        check_phase("ilv", sum);

        do_clear(4, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            drive(1, 2, 65535);
            drive(1, 3, -65536);
        end
        drain();
        chk("sat.cnt", got_q.size(), 8);
        if (got_q.size() >= 2) begin
            chk("sat.pos", got_q[got_q.size()-2].data, 8191);
            chk("sat.pos_flag", got_q[got_q.size()-2].sat, 1);
            chk("sat.neg", got_q[got_q.size()-1].data, -8192);
            chk("sat.neg_flag", got_q[got_q.size()-1].sat, 1);
        end
        check_phase("sat", sum);

        // Clamp edges plus invalid channels 5..7 mixed in
        do_clear(1, 31, 0, 0, 0);
        for (int i = 0; i < 40; i++) begin
            x = int'($urandom_range(0, 4000)) - 2000;
            drive(1, $urandom_range(0, 7), x);
        end
        check_phase("clampr2", sum);
        do_clear(31, 0, 0, 0, 0);
        for (int i = 0; i < 40; i++) begin
            x = int'($urandom_range(0, 400)) - 200;
            drive(1, $urandom_range(0, 7), x);
        end
        check_phase("clampr16", sum);

        // Clear right after a decimating strobe, with a strobe of its own and 8->16
        do_clear(8, 3, 0, 0, 0);
        for (int i = 0; i < 8; i++) drive(1, 0, 700 + i);
        do_clear(16, 3, 1, 0, 12345);
        for (int i = 0; i < 32; i++) drive(1, 0, 500);
        check_phase("clr", sum);

        for (int t = 0; t < 3; t++) begin
            x = int'($urandom_range(0, 131071)) - 65536;
            do_clear($urandom_range(0, 31), $urandom_range(0, 31), 1, $urandom_range(0, 7), x);
            for (int i = 0; i < 200; i++) begin
                x = int'($urandom_range(0, 131071)) - 65536;
                drive($urandom_range(0, 9) < 7, $urandom_range(0, 7), x);
            end
            check_phase($sformatf("rnd%0d", t), sum);
        end

        // Asynchronous reset while a result is in flight
        do_clear(4, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) drive(1, 2, 20000);
        repeat (6) drive(0, 0, 0);
        for (int i = 0; i < 4; i++) drive(1, 2, 20000);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("arst.data", longint'(out_data), 0);
        chk("arst.ch", int'(out_ch), 0);
        chk("arst.str", int'(out_str), 0);
        chk("arst.sat", int'(out_sat), 0);
        while (exp_q.size() > 0 && exp_q[$].cyc >= cyc) void'(exp_q.pop_back());
        model_init(CIC_R_MAX, ACC_W - OUT_DW);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        check_phase("arst", sum);

        for (int i = 0; i < 48; i++) drive(1, 4, -30000);
        check_phase("post", sum);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
